// File: rtl/accel_entropy_pool_if.sv
// Sample-in / byte-out handshake bundle for the accelerometer entropy pool.
// slave is the pool's view; master is the reader/consumer side.
interface accel_entropy_pool_if #(
  parameter int COORD_WIDTH = 16
);
  logic                   sample_valid;
  logic [COORD_WIDTH-1:0] x;
  logic [COORD_WIDTH-1:0] y;
  logic [7:0]             out_data;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output sample_valid, x, y, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  sample_valid, x, y, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/accel_entropy_pool.sv
// Von Neumann debiased noise harvest from accelerometer LSBs into a FWFT byte FIFO; pair k of a
// capture is processed k+1 cycles after the edge. Optional stuck-sample alarm: ACCEL_ENTROPY_HEALTH_EN.
module accel_entropy_pool #(
  parameter int COORD_WIDTH     = 16,
  parameter int LSB_OFFSET      = 4,
  parameter int BITS_PER_COORD  = 2,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int STUCK_LIMIT     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  accel_entropy_pool_if.slave        bus,
  output logic [FIFO_DEPTH_LOG2:0]   fill_level,
  output logic                       overflow,
  output logic                       health_fail
);
  localparam int RW    = 2 * BITS_PER_COORD;
  localparam int KW    = (BITS_PER_COORD > 1) ? $clog2(BITS_PER_COORD) : 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  if (BITS_PER_COORD < 1 || BITS_PER_COORD > 4 || STUCK_LIMIT < 2 ||
      COORD_WIDTH < LSB_OFFSET + BITS_PER_COORD) begin : g_param_check
    $error("accel_entropy_pool: parameter out of range");
  end

  typedef enum logic {IDLE, EXTRACT} state_t;

  state_t                      state_q, state_d;
  logic                        sv_q;
  logic [RW-1:0]               r_q, r_d, r_sh;
  logic [KW-1:0]               k_q, k_d;
  logic [6:0]                  acc_q, acc_d;
  logic [2:0]                  cnt_q, cnt_d;
  logic                        rise, capture, bit_vld, bit_val, push;
  logic [7:0]                  push_byte;
  logic [RW-1:0]               raw;
  logic                        health_fail_q;

  logic [7:0]                  mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0]  wr_q, rd_q;
  logic [FIFO_DEPTH_LOG2:0]    fill_q;
  logic                        overflow_q, full, pop, push_go, drop;

  assign rise    = bus.sample_valid && !sv_q;
  assign capture = (state_q == IDLE) && rise;
  assign raw     = {bus.y[LSB_OFFSET +: BITS_PER_COORD], bus.x[LSB_OFFSET +: BITS_PER_COORD]};
  assign r_sh    = r_q >> {k_q, 1'b0};

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    k_d       = k_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    bit_vld   = 1'b0;
    bit_val   = 1'b0;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          r_d     = raw;
          k_d     = '0;
          state_d = EXTRACT;
        end
      end
      EXTRACT: begin
        bit_val = r_sh[0];
        bit_vld = r_sh[0] != r_sh[1];
        if (k_q == KW'(BITS_PER_COORD - 1)) state_d = IDLE;
        else                                k_d     = k_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // 3-bit count wraps to 0 exactly when the eighth bit completes a byte
    if (bit_vld) begin
      acc_d = {acc_q[5:0], bit_val};
      cnt_d = cnt_q + 3'd1;
      push  = (cnt_q == 3'd7);
    end
    push_byte = {acc_q, bit_val};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sv_q    <= 1'b0;
      r_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sv_q    <= bus.sample_valid;
      r_q     <= r_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ACCEL_ENTROPY_HEALTH_EN
  localparam int SW = $clog2(STUCK_LIMIT) + 1;

  logic [2*COORD_WIDTH-1:0] prev_q;
  logic                     prev_vld_q;
  logic [SW-1:0]            stuck_q, stuck_d;
  logic                     health_fail_d;

  always_comb begin
    stuck_d       = stuck_q;
    health_fail_d = health_fail_q;
    if (capture) begin
      if (!(prev_vld_q && ({bus.x, bus.y} == prev_q))) stuck_d = '0;
      else if (stuck_q != SW'(STUCK_LIMIT - 1))         stuck_d = stuck_q + 1'b1;
      if (stuck_d == SW'(STUCK_LIMIT - 1)) health_fail_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q        <= '0;
      prev_vld_q    <= 1'b0;
      stuck_q       <= '0;
      health_fail_q <= 1'b0;
    end else begin
      if (capture) begin
        prev_q     <= {bus.x, bus.y};
        prev_vld_q <= 1'b1;
      end
      stuck_q       <= stuck_d;
      health_fail_q <= health_fail_d;
    end
  end
`else
  logic unused_coord;
  assign unused_coord  = ^{bus.x, bus.y};
  assign health_fail_q = 1'b0;
`endif

  // A full FIFO can still take a byte when the consumer pops in the same cycle
  assign full    = fill_q == (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  assign pop     = bus.out_valid && bus.out_ready;
  assign push_go = push && !health_fail_q && (!full || pop);
  assign drop    = push && !health_fail_q && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_go) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      if (push_go && !pop)      fill_q <= fill_q + 1'b1;
      else if (!push_go && pop) fill_q <= fill_q - 1'b1;
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_go) mem_q[wr_q] <= push_byte;
  end

  assign bus.out_valid = (fill_q != '0) && !health_fail_q;
  assign bus.out_data  = (fill_q != '0) ? mem_q[rd_q] : 8'h00;
  assign fill_level    = fill_q;
  assign overflow      = overflow_q;
  assign health_fail   = health_fail_q;
endmodule

// File: tb/tb_accel_entropy_pool.sv
// Randomized bench for accel_entropy_pool against a bit-stream reference model.
module tb_accel_entropy_pool;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] fill_level;
  logic       overflow;
  logic       health_fail;

  accel_entropy_pool_if #(.COORD_WIDTH(16)) bus ();

  accel_entropy_pool dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fill_level (fill_level),
    .overflow   (overflow),
    .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  int         tests_run = 0;
  int         fails     = 0;
  bit         bitq[$];
  logic [7:0] expq[$];

  // Reference: debiased bits form one stream; every 8 bits form a byte, first bit at MSB.
  function automatic void model_sample(logic [15:0] xv, logic [15:0] yv);
    logic [3:0] r;
    logic [7:0] b;
    r = {yv[5:4], xv[5:4]};
    for (int k = 0; k < 2; k++) begin
      if (r[2*k] != r[2*k+1]) bitq.push_back(r[2*k]);
      if (bitq.size() == 8) begin
        for (int i = 0; i < 8; i++) b[7-i] = bitq[i];
        expq.push_back(b);
        bitq.delete();
      end
    end
  endfunction

  task automatic send(input logic [15:0] xv, input logic [15:0] yv, input int hold, input int low);
    @(negedge clk);
    bus.x = xv;
    bus.y = yv;
    bus.sample_valid = 1'b1;
    model_sample(xv, yv);
    repeat (hold) @(negedge clk);
    bus.sample_valid = 1'b0;
    repeat (low) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bitq.delete();
    expq.delete();
  endtask

  task automatic test_reset();
    bus.x = 16'($urandom);
    bus.y = 16'($urandom);
    do_reset();
    tests_run++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    tests_run++; if (fill_level !== 5'd0) begin fails++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
    tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    tests_run++; if (health_fail !== 1'b0) begin fails++; $display("FAIL reset_health: got %b want 0", health_fail); end
    tests_run++; if (bus.out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
  endtask

  task automatic test_aa_byte();
    do_reset();
    repeat (3) send(16'h0010, 16'h0020, 1, 3);
    @(negedge clk);
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    tests_run++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL aa_early0: got %b want 0", bus.out_valid); end
    @(negedge clk);
    tests_run++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL aa_early1: got %b want 0", bus.out_valid); end
    @(negedge clk);
    tests_run++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL aa_valid: got %b want 1", bus.out_valid); end
    tests_run++; if (bus.out_data !== 8'hAA) begin fails++; $display("FAIL aa_data: got %h want aa", bus.out_data); end
    tests_run++; if (fill_level !== 5'd1) begin fails++; $display("FAIL aa_fill: got %0d want 1", fill_level); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    tests_run++; if (fill_level !== 5'd0) begin fails++; $display("FAIL aa_pop_fill: got %0d want 0", fill_level); end
  endtask

  task automatic test_discard();
    int guard;
    do_reset();
    for (int i = 0; i < 8; i++)
      send(($urandom_range(0, 1) != 0) ? 16'h0030 : 16'h0000,
           ($urandom_range(0, 1) != 0) ? 16'h0030 : 16'h0000, 1, 3);
    tests_run++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL discard_valid: got %b want 0", bus.out_valid); end
    tests_run++; if (fill_level !== 5'd0) begin fails++; $display("FAIL discard_fill: got %0d want 0", fill_level); end
    guard = 0;
    while (expq.size() < 1 && guard < 200) begin
      send(16'($urandom), 16'($urandom), 1, 3);
      guard++;
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (expq.size() != 1 || bus.out_valid !== 1'b1 || bus.out_data !== expq[0]) begin
      fails++;
      $display("FAIL discard_burst: got valid=%b data=%h want valid=1 data=%h", bus.out_valid, bus.out_data,
               (expq.size() > 0) ? expq[0] : 8'hxx);
    end
  endtask

  task automatic test_level_hold();
    do_reset();
    @(negedge clk);
    bus.x = 16'h0010;
    bus.y = 16'h0020;
    bus.sample_valid = 1'b1;
    repeat (100) @(negedge clk);
    bus.sample_valid = 1'b0;
    repeat (4) @(negedge clk);
    bus.sample_valid = 1'b1;
    repeat (5) @(negedge clk);
    bus.sample_valid = 1'b0;
    repeat (4) @(negedge clk);
    send(16'h0010, 16'h0020, 1, 3);
    tests_run++; if (fill_level !== 5'd0) begin fails++; $display("FAIL hold_three_caps: got fill %0d want 0", fill_level); end
    send(16'h0010, 16'h0020, 1, 3);
    tests_run++; if (fill_level !== 5'd1) begin fails++; $display("FAIL hold_fill: got %0d want 1", fill_level); end
    tests_run++; if (bus.out_data !== 8'hAA) begin fails++; $display("FAIL hold_data: got %h want aa", bus.out_data); end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] ax, ay;
    int          guard;
    do_reset();
    ax = 16'($urandom);
    ay = 16'($urandom);
    @(negedge clk);
    bus.x = ax;
    bus.y = ay;
    bus.sample_valid = 1'b1;
    model_sample(ax, ay);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    @(negedge clk);
    bus.x = 16'h0010;
    bus.y = 16'h0020;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    guard = 0;
    while (expq.size() < 2 && guard < 300) begin
      send(16'($urandom), 16'($urandom), 1, 3);
      guard++;
    end
    for (int i = 0; i < 2; i++) begin
      bus.out_ready = 1'b1;
      tests_run++;
      if (bus.out_valid !== 1'b1 || expq.size() == 0 || bus.out_data !== expq[0]) begin
        fails++;
        $display("FAIL busy_byte%0d: got valid=%b data=%h want valid=1 data=%h", i, bus.out_valid, bus.out_data,
                 (expq.size() > 0) ? expq[0] : 8'hxx);
      end
      if (expq.size() > 0) void'(expq.pop_front());
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int guard;
    do_reset();
    guard = 0;
    while (expq.size() < 17 && guard < 2000) begin
      send(16'($urandom), 16'($urandom), $urandom_range(1, 2), 3);
      guard++;
    end
    repeat (2) @(negedge clk);
    tests_run++; if (fill_level !== 5'd16) begin fails++; $display("FAIL ovf_fill: got %0d want 16", fill_level); end
    tests_run++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    if (expq.size() == 17) void'(expq.pop_back());
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (bus.out_valid !== 1'b1 || expq.size() == 0 || bus.out_data !== expq[0]) begin
        fails++;
        $display("FAIL ovf_byte%0d: got valid=%b data=%h want valid=1 data=%h", i, bus.out_valid, bus.out_data,
                 (expq.size() > 0) ? expq[0] : 8'hxx);
      end
      if (expq.size() > 0) void'(expq.pop_front());
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    tests_run++; if (fill_level !== 5'd0) begin fails++; $display("FAIL ovf_drained: got %0d want 0", fill_level); end
    tests_run++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (4) send(16'h0010, 16'h0020, 1, 3);
    repeat (2) send(16'h0010, 16'h0020, 1, 3);
    send(16'h0010, 16'h0000, 1, 3);
    @(negedge clk);
    bus.sample_valid = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %b want 0", bus.out_valid); end
    tests_run++; if (fill_level !== 5'd0) begin fails++; $display("FAIL rmid_fill: got %0d want 0", fill_level); end
    tests_run++; if (bus.out_data !== 8'h00) begin fails++; $display("FAIL rmid_data: got %h want 00", bus.out_data); end
    rst = 1'b0;
    bitq.delete();
    expq.delete();
    repeat (4) send(16'h0010, 16'h0020, 1, 3);
    tests_run++; if (fill_level !== 5'd1) begin fails++; $display("FAIL rmid_fresh_fill: got %0d want 1", fill_level); end
    tests_run++; if (bus.out_data !== 8'hAA) begin fails++; $display("FAIL rmid_fresh_data: got %h want aa", bus.out_data); end
  endtask

  task automatic test_random_stream();
    bit   done;
    bit   r;
    int   cyc;
    do_reset();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++)
          send(16'($urandom), 16'($urandom), $urandom_range(1, 3), $urandom_range(3, 6));
        done = 1'b1;
      end
      begin
        cyc = 0;
        while (!(done && expq.size() == 0) && cyc < 5000) begin
          @(negedge clk);
          r = ($urandom_range(0, 3) != 0);
          bus.out_ready = r;
          if (bus.out_valid && r) begin
            tests_run++;
            if (expq.size() == 0 || bus.out_data !== expq[0]) begin
              fails++;
              $display("FAIL rand_byte: got %h want %h", bus.out_data, (expq.size() > 0) ? expq[0] : 8'hxx);
            end
            if (expq.size() > 0) void'(expq.pop_front());
          end
          cyc++;
        end
      end
    join
    @(negedge clk);
    bus.out_ready = 1'b0;
    tests_run++; if (expq.size() != 0) begin fails++; $display("FAIL rand_timeout: got %0d pending want 0", expq.size()); end
    tests_run++; if (fill_level !== 5'd0) begin fails++; $display("FAIL rand_fill: got %0d want 0", fill_level); end
    tests_run++; if (overflow !== 1'b0) begin fails++; $display("FAIL rand_overflow: got %b want 0", overflow); end
  endtask

`ifdef ACCEL_ENTROPY_HEALTH_EN
  task automatic test_health();
    do_reset();
    repeat (7) send(16'h1230, 16'h4560, 1, 3);
    tests_run++; if (health_fail !== 1'b0) begin fails++; $display("FAIL health_early: got %b want 0", health_fail); end
    send(16'h1230, 16'h4560, 1, 3);
    tests_run++; if (health_fail !== 1'b1) begin fails++; $display("FAIL health_trip: got %b want 1", health_fail); end
    tests_run++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL health_valid: got %b want 0", bus.out_valid); end
    tests_run++; if (fill_level !== 5'd0) begin fails++; $display("FAIL health_nopush: got %0d want 0", fill_level); end
    send(16'h0010, 16'h0020, 1, 3);
    tests_run++; if (health_fail !== 1'b1) begin fails++; $display("FAIL health_sticky: got %b want 1", health_fail); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_aa_byte();
    test_discard();
    test_level_hold();
    test_busy_ignore();
    test_overflow();
    test_reset_mid();
    test_random_stream();
`ifdef ACCEL_ENTROPY_HEALTH_EN
    test_health();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/accel_entropy_pool.md
Name: accel_entropy_pool

Overview:
- Consumes x/y coordinate samples from the ADXL362 SPI reader and harvests sensor noise from their low-order valid bits.
- Debiases the harvested bits with a von Neumann extractor and packs them into bytes.
- Buffers the bytes in a small FIFO and presents them on a valid/ready byte stream.
- Sits between the accelerometer reader and the key/nonce generation logic of the encrypted ethernet path; it is the entropy source for the rng top.

Parameters:
- COORD_WIDTH, 16: width of the x/y inputs; must match the reader.
- LSB_OFFSET, 4: index of the lowest meaningful coordinate bit. The reader zero-fills bits [3:0].
- BITS_PER_COORD, 2: noise bits taken from each coordinate, range 1..4.
- FIFO_DEPTH_LOG2, 4: FIFO holds 2^FIFO_DEPTH_LOG2 bytes.
- STUCK_LIMIT, 8: consecutive identical samples that trip the health test (optional feature only).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- sample_valid, input, 1: reader frame flag (reader outclk). A rising edge marks a new x/y pair.
- x, input, COORD_WIDTH: signed x sample, stable while sample_valid is high.
- y, input, COORD_WIDTH: signed y sample, same rule.
- out_data, output, 8: head-of-FIFO byte (first-word fall-through).
- out_valid, output, 1: FIFO not empty.
- out_ready, input, 1: consumer accepts out_data when out_valid && out_ready.
- fill_level, output, FIFO_DEPTH_LOG2+1: bytes currently held.
- overflow, output, 1: sticky; set when a completed byte is dropped.
- health_fail, output, 1: sticky health alarm; constant 0 without the optional feature.

Behaviour:
- Reset values: out_valid=0, fill_level=0, overflow=0, health_fail=0, out_data=0; FSM in IDLE; bit accumulator and bit count cleared.
- Edge detect: sample_valid is registered; rising edge = registered 0 and current 1. A level held high produces exactly one capture.
- Raw vector R, 2*BITS_PER_COORD bits = {y[LSB_OFFSET +: BITS_PER_COORD], x[LSB_OFFSET +: BITS_PER_COORD]}. Captured into a register in the edge cycle (cycle N).
- IDLE: on a rising edge, capture R, clear pair index k, go to EXTRACT.
- EXTRACT: one pair per cycle, k = 0..BITS_PER_COORD-1, using bits a=R[2k] and b=R[2k+1].
  - a != b: emit bit a.
  - a == b: discard.
  - After the last pair, return to IDLE. Pair k is processed in cycle N+1+k.
- Rising edges seen while in EXTRACT are ignored; no sample is queued.
- Byte packing: acc <= {acc[6:0], bit}, so the first emitted bit lands at the MSB.
  - On the 8th bit, the full byte is pushed into the FIFO in the same cycle and the bit count returns to 0.
  - out_valid rises the following cycle if the FIFO was empty.
  - The bit count and acc persist across samples.
- FIFO: circular buffer with a pointer wrap at depth.
  - Pop on out_valid && out_ready.
  - Push when full with no pop in that cycle: byte dropped, overflow <= 1 (sticky until rst).
  - Push and pop in the same cycle when full: both proceed, fill_level unchanged.
  - Push and pop in the same cycle when empty: not possible, since out_valid=0.
- Reset mid-extraction discards the partial byte and all FIFO contents.

Optional Feature:
- Macro: ACCEL_ENTROPY_HEALTH_EN.
- Defined:
  - Compare each captured {x,y} (full width) against the previous capture.
  - A saturating counter counts consecutive identical samples; it resets to 0 on any difference.
  - When the counter reaches STUCK_LIMIT-1 repeats (STUCK_LIMIT identical samples in total), health_fail <= 1 (sticky until rst).
  - While health_fail=1: no further bytes are pushed and out_valid is forced to 0; FIFO contents are retained but not popped.
- Undefined: no comparator or counter is built; health_fail is tied to 0.

Test Plan:
- Four rising edges with x=16'h0010, y=16'h0020 (R=4'b1001, emits 1 then 0) -> exactly one byte, out_data=8'hAA, out_valid high 1 cycle after the 4th sample's last pair; fill_level=1.
- Samples with x=16'h0000/16'h0030, y=16'h0000/16'h0030 (all pairs equal) -> no bit emitted, out_valid stays 0; a following 8-bit burst still yields a correct byte.
- sample_valid held high for 100 cycles, then low, then high -> exactly two captures.
- out_ready=0 and 17 bytes generated (depth 16) -> fill_level=16, overflow=1, first 16 bytes read back in order after out_ready=1.
- rst asserted during EXTRACT after 5 accumulated bits -> all outputs at reset values next cycle; 8 more bits then form a fresh byte with no residue.
- With ACCEL_ENTROPY_HEALTH_EN: 8 identical samples x=16'h1230, y=16'h4560 -> health_fail=1 on the 8th capture, out_valid=0; one differing sample does not clear it.
